cmp_hysteresis_monitor: RTL

- Sits directly downstream of the 3-bit magnitude comparator and consumes its Equal / A_more / B_more flags once per valid sample.
- Filters the flags with a consecutive-sample hysteresis FSM and drives a registered alarm level (A persistently greater than B).
- Reports each alarm edge through a one-entry valid/ready event register.
- Flags illegal comparator flag combinations as a sticky error.

---
 rtl/cmp_pkg.sv | 35 +++
 rtl/cmp_hysteresis_monitor_if.sv | 29 ++
 rtl/cmp_evt_slot.sv | 57 +++++
 rtl/cmp_hysteresis_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator hysteresis monitor: FSM state
// encoding, event type constants and the flag-classification helper.
// Optional rise counter in the top is enabled by CMP_HYST_RISE_COUNT_EN.
package cmp_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } hyst_state_e;

    typedef enum logic [1:0] {
        CLS_RAISE   = 2'd0,
        CLS_RELEASE = 2'd1,
        CLS_ILLEGAL = 2'd2
    } sample_cls_e;

    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

    // A healthy comparator asserts exactly one flag; anything else is illegal
    function automatic sample_cls_e classify_flags(input logic equalFlag,
                                                   input logic aMoreFlag,
                                                   input logic bMoreFlag);
        sample_cls_e cls;
        case ({equalFlag, aMoreFlag, bMoreFlag})
            3'b010:         cls = CLS_RAISE;
            3'b100, 3'b001: cls = CLS_RELEASE;
            default:        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cmp_hysteresis_monitor_if.sv
// Bundle of comparator-flag inputs, event handshake and status outputs of
// the hysteresis monitor. The slave modport is the monitor's view; the
// master modport is the view of whatever drives flags and consumes events.
interface cmp_hysteresis_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             equal;
    logic             a_more;
    logic             b_more;
    logic             err_clr;
    logic             evt_ready;
    logic             alarm;
    logic             evt_valid;
    logic             evt_type;
    logic             evt_ovf;
    logic             err_sticky;
    logic [CNT_W-1:0] rise_cnt;

    modport master (
        output in_valid, equal, a_more, b_more, err_clr, evt_ready,
        input  alarm, evt_valid, evt_type, evt_ovf, err_sticky, rise_cnt
    );

    modport slave (
        input  in_valid, equal, a_more, b_more, err_clr, evt_ready,
        output alarm, evt_valid, evt_type, evt_ovf, err_sticky, rise_cnt
    );
endinterface

// File: rtl/cmp_evt_slot.sv
// One-entry valid/ready event register. A new event loads when the slot is
// empty or is being drained in the same cycle; otherwise it is dropped and
// the sticky overflow flag records the loss.
module cmp_evt_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic evt_i,
    input  logic evt_type_i,
    input  logic ready_i,
    input  logic err_clr_i,
    output logic valid_o,
    output logic type_o,
    output logic ovf_o
);
    logic valid_q, valid_d;
    logic type_q, type_d;
    logic ovf_q, ovf_d;
    logic loadEvt;
    logic dropEvt;

    // Decide whether an incoming event is stored or lost, and when the slot drains
    always_comb begin
        loadEvt = evt_i && (!valid_q || ready_i);
        dropEvt = evt_i && valid_q && !ready_i;
        valid_d = valid_q;
        type_d  = type_q;
        ovf_d   = ovf_q;
        if (loadEvt) begin
            valid_d = 1'b1;
            type_d  = evt_type_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
        if (dropEvt) begin
            ovf_d = 1'b1;
        end else if (err_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Slot registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            type_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign type_o  = type_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/cmp_hysteresis_monitor.sv
// Hysteresis filter on 3-bit comparator flags. A run of SET_COUNT a_more
// samples raises the alarm, a run of CLR_COUNT equal/b_more samples drops
// it; each alarm edge is reported through a one-entry event slot.
// Define CMP_HYST_RISE_COUNT_EN to build the saturating rise-event counter;
// otherwise rise_cnt is tied to zero.
module cmp_hysteresis_monitor
    import cmp_pkg::*;
#(
    parameter int SET_COUNT = 4,
    parameter int CLR_COUNT = 2,
    parameter int CNT_W     = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    cmp_hysteresis_monitor_if.slave mon
);
    localparam int MAX_CNT = (SET_COUNT > CLR_COUNT) ? SET_COUNT : CLR_COUNT;
    localparam int RUN_W   = $clog2(MAX_CNT + 1);
    localparam logic [RUN_W-1:0] SET_RUN = RUN_W'(SET_COUNT);
    localparam logic [RUN_W-1:0] CLR_RUN = RUN_W'(CLR_COUNT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    hyst_state_e      state_q, state_d;
    logic [RUN_W-1:0] runCnt_q, runCnt_d;
    logic             alarm_q, alarm_d;
    logic             errSticky_q, errSticky_d;
    sample_cls_e      sampleCls;
    logic             illegalSample;
    logic             riseEvt;
    logic             fallEvt;
    logic             slotValid;
    logic             slotType;
    logic             slotOvf;

    // Next-state logic: count consecutive qualifying samples, emit edge events
    always_comb begin
        state_d       = state_q;
        runCnt_d      = runCnt_q;
        riseEvt       = 1'b0;
        fallEvt       = 1'b0;
        sampleCls     = classify_flags(mon.equal, mon.a_more, mon.b_more);
        illegalSample = mon.in_valid && (sampleCls == CLS_ILLEGAL);
        if (mon.in_valid) begin
            case (state_q)
                LOW: begin
                    if (sampleCls == CLS_RAISE) begin
                        runCnt_d = RUN_ONE;
                        if (SET_COUNT == 1) begin
                            state_d = HIGH;
                            riseEvt = 1'b1;
                        end else begin
                            state_d = PEND_HIGH;
                        end
                    end else begin
                        runCnt_d = '0;
                    end
                end
                PEND_HIGH: begin
                    if (sampleCls == CLS_RAISE) begin
                        if (runCnt_q + RUN_ONE == SET_RUN) begin
                            state_d  = HIGH;
                            runCnt_d = '0;
                            riseEvt  = 1'b1;
                        end else begin
                            runCnt_d = runCnt_q + RUN_ONE;
                        end
                    end else begin
                        state_d  = LOW;
                        runCnt_d = '0;
                    end
                end
                HIGH: begin
                    if (sampleCls == CLS_RELEASE) begin
                        runCnt_d = RUN_ONE;
                        if (CLR_COUNT == 1) begin
                            state_d = LOW;
                            fallEvt = 1'b1;
                        end else begin
                            state_d = PEND_LOW;
                        end
                    end else begin
                        runCnt_d = '0;
                    end
                end
                PEND_LOW: begin
                    if (sampleCls == CLS_RELEASE) begin
                        if (runCnt_q + RUN_ONE == CLR_RUN) begin
                            state_d  = LOW;
                            runCnt_d = '0;
                            fallEvt  = 1'b1;
                        end else begin
                            runCnt_d = runCnt_q + RUN_ONE;
                        end
                    end else begin
                        state_d  = HIGH;
                        runCnt_d = '0;
                    end
                end
                default: begin
                    state_d  = LOW;
                    runCnt_d = '0;
                end
            endcase
        end
        alarm_d = (state_d == HIGH) || (state_d == PEND_LOW);
        if (illegalSample) begin
            errSticky_d = 1'b1;
        end else if (mon.err_clr) begin
            errSticky_d = 1'b0;
        end else begin
            errSticky_d = errSticky_q;
        end
    end

    // FSM, run counter, alarm level and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOW;
            runCnt_q    <= '0;
            alarm_q     <= 1'b0;
            errSticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            runCnt_q    <= runCnt_d;
            alarm_q     <= alarm_d;
            errSticky_q <= errSticky_d;
        end
    end

    cmp_evt_slot u_evt_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_i     (riseEvt | fallEvt),
        .evt_type_i(riseEvt ? EVT_RISE : EVT_FALL),
        .ready_i   (mon.evt_ready),
        .err_clr_i (mon.err_clr),
        .valid_o   (slotValid),
        .type_o    (slotType),
        .ovf_o     (slotOvf)
    );

`ifdef CMP_HYST_RISE_COUNT_EN
    logic [CNT_W-1:0] riseCnt_q, riseCnt_d;

    // Rise events are counted whether or not the slot accepted them; stop at all-ones
    always_comb begin
        riseCnt_d = riseCnt_q;
        if (riseEvt && (riseCnt_q != {CNT_W{1'b1}})) begin
            riseCnt_d = riseCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Rise counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            riseCnt_q <= '0;
        end else begin
            riseCnt_q <= riseCnt_d;
        end
    end

    assign mon.rise_cnt = riseCnt_q;
`else
    assign mon.rise_cnt = {CNT_W{1'b0}};
`endif

    assign mon.alarm      = alarm_q;
    assign mon.err_sticky = errSticky_q;
    assign mon.evt_valid  = slotValid;
    assign mon.evt_type   = slotType;
    assign mon.evt_ovf    = slotOvf;
endmodule
